// File: rtl/llsc_reservation_unit.sv
// LR.W / SC.W reservation tracker for one core's MEM stage.
// Holds a single block-granular reservation and clears it on snoop invalidations.
// Gates the SC store request to the dcache and returns the SC result word.
// Stalls the upstream pipeline while an atomic access is in flight.
module llsc_reservation_unit #(
  parameter int ADDR_W    = 32,
  parameter int GRAN_BITS = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              mem_valid,
  input  logic              atomic,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              halt,
  input  logic [ADDR_W-1:0] addr,
  input  logic              dhit,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              dmem_ren,
  output logic              dmem_wen,
  output logic [31:0]       sc_result,
  output logic              atomic_stall,
  output logic              resv_valid,
  output logic [ADDR_W-1:0] resv_addr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LR_WAIT = 2'd1,
    SC_WAIT = 2'd2,
    SC_FAIL = 2'd3
  } state_t;

  // Clears the offset bits inside a reservation block.
  localparam logic [ADDR_W-1:0] BLK_MASK = {{(ADDR_W-GRAN_BITS){1'b1}}, {GRAN_BITS{1'b0}}};

  state_t              r_state;
  logic                r_resv_valid;
  logic [ADDR_W-1:0]   r_resv_addr;
  logic [31:0]         r_sc_result;

  logic                w_resv_valid_next;
  logic [ADDR_W-1:0]   w_resv_addr_next;

  logic w_live, w_dec, w_lr, w_sc, w_st, w_ld;
  logic w_sc_ok, w_lr_done, w_sc_done, w_snoop_hit;

  function automatic logic blk_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:GRAN_BITS] == b[ADDR_W-1:GRAN_BITS];
  endfunction

  // Request/stall outputs are qualified by nRST so they fall the instant reset asserts;
  // halt also suppresses new requests so nothing is left outstanding.
  assign w_live = nRST & ~halt;
  assign w_dec  = (r_state == IDLE) & mem_valid & w_live;
  assign w_lr   = w_dec & atomic & mem_read;
  assign w_sc   = w_dec & atomic & mem_write & ~mem_read;
  assign w_st   = w_dec & ~atomic & mem_write;
  assign w_ld   = w_dec & ~atomic & mem_read;

  // An SC succeeds only if the reservation covers its block and is not being killed this cycle.
  assign w_sc_ok = r_resv_valid & blk_match(addr, r_resv_addr) &
                   ~(snoop_inv & blk_match(snoop_addr, r_resv_addr));

  assign w_lr_done   = (r_state == LR_WAIT) & dhit & w_live;
  assign w_sc_done   = (r_state == SC_WAIT) & dhit & w_live;
  assign w_snoop_hit = snoop_inv & r_resv_valid & blk_match(snoop_addr, r_resv_addr);

  // Dcache requests, pipeline stall and SC result word.
  always_comb begin
    dmem_ren     = w_ld | w_lr | ((r_state == LR_WAIT) & w_live);
    dmem_wen     = w_st | (w_sc & w_sc_ok) | ((r_state == SC_WAIT) & w_live);
    atomic_stall = w_lr | w_sc |
                   (((r_state == LR_WAIT) | (r_state == SC_WAIT)) & w_live & ~dhit);
    if (r_state == SC_FAIL)
      sc_result = 32'd1;
    else if (w_sc_done)
      sc_result = 32'd0;
    else
      sc_result = r_sc_result;
  end

  // Next reservation; later assignments take priority (snoop and halt clear last).
  always_comb begin
    w_resv_valid_next = r_resv_valid;
    w_resv_addr_next  = r_resv_addr;
    if (w_st & dhit & blk_match(addr, r_resv_addr))
      w_resv_valid_next = 1'b0;
    if (w_sc & ~w_sc_ok)
      w_resv_valid_next = 1'b0;
    if (w_lr_done) begin
      w_resv_valid_next = ~(snoop_inv & blk_match(snoop_addr, addr));
      w_resv_addr_next  = addr & BLK_MASK;
    end
    if (w_sc_done)
      w_resv_valid_next = 1'b0;
    if (w_snoop_hit | halt)
      w_resv_valid_next = 1'b0;
  end

  // Atomic sequencing FSM with registered reservation and SC result.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_resv_valid <= 1'b0;
      r_resv_addr  <= '0;
      r_sc_result  <= 32'd0;
    end else begin
      r_resv_valid <= w_resv_valid_next;
      r_resv_addr  <= w_resv_addr_next;
      if (halt) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_lr)
              r_state <= LR_WAIT;
            else if (w_sc)
              r_state <= w_sc_ok ? SC_WAIT : SC_FAIL;
          end
          LR_WAIT: begin
            if (dhit)
              r_state <= IDLE;
          end
          SC_WAIT: begin
            if (dhit) begin
              r_state     <= IDLE;
              r_sc_result <= 32'd0;
            end
          end
          SC_FAIL: begin
            r_state     <= IDLE;
            r_sc_result <= 32'd1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign resv_valid = r_resv_valid;
  assign resv_addr  = r_resv_addr;

endmodule

// File: tb/tb_llsc_reservation_unit.sv
// Scoreboard bench for llsc_reservation_unit: each operation pushes its expected
// stall/request counts and reservation state, then pops and compares once it completes.
module tb_llsc_reservation_unit;

  localparam int OP_LR = 0, OP_SC = 1, OP_ST = 2, OP_LD = 3;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        mem_valid = 1'b0, atomic = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic        halt = 1'b0, dhit = 1'b0, snoop_inv = 1'b0;
  logic [31:0] addr = '0, snoop_addr = '0;
  logic        dmem_ren, dmem_wen, atomic_stall, resv_valid;
  logic [31:0] sc_result, resv_addr;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        m_rv = 1'b0;
  logic [31:0] m_ra = '0;

  always #5 CLK = ~CLK;

  llsc_reservation_unit #(.ADDR_W(32), .GRAN_BITS(3)) dut (
    .CLK(CLK), .nRST(nRST), .mem_valid(mem_valid), .atomic(atomic),
    .mem_read(mem_read), .mem_write(mem_write), .halt(halt), .addr(addr),
    .dhit(dhit), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .sc_result(sc_result),
    .atomic_stall(atomic_stall), .resv_valid(resv_valid), .resv_addr(resv_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  function automatic logic same_blk(input logic [31:0] a, input logic [31:0] b);
    return a[31:3] == b[31:3];
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    mem_valid = 0; atomic = 0; mem_read = 0; mem_write = 0;
    dhit = 0; snoop_inv = 0; halt = 0;
  endtask

  // Pop every pending expectation and compare with the observed values.
  task automatic drain(input int stall_n, input int wen_n, input int ren_n, input logic [31:0] scr);
    exp_t  e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.tag)
        "stall_cycles": obs = 32'(stall_n);
        "wen_cycles":   obs = 32'(wen_n);
        "ren_cycles":   obs = 32'(ren_n);
        "sc_result":    obs = scr;
        "resv_valid":   obs = {31'd0, resv_valid};
        "resv_addr":    obs = resv_addr;
        default:        obs = 32'hDEAD_BEEF;
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  // One MEM-stage operation; dhit arrives lat cycles after the entry cycle.
  task automatic run_op(input int op, input logic [31:0] ad, input int lat, input logic snp_dhit);
    int          stall_n = 0, wen_n = 0, ren_n = 0;
    logic [31:0] scr_obs = '0;
    bit          done = 0;
    bit          succ;
    // Model and expectation push.
    case (op)
      OP_LR: begin
        push("stall_cycles", 32'(lat));
        push("wen_cycles", 0);
        push("ren_cycles", 32'(lat + 1));
        m_rv = !snp_dhit;
        m_ra = ad & 32'hFFFF_FFF8;
      end
      OP_SC: begin
        succ = m_rv && same_blk(ad, m_ra);
        push("stall_cycles", succ ? 32'(lat) : 32'd1);
        push("wen_cycles", succ ? 32'(lat + 1) : 32'd0);
        push("ren_cycles", 0);
        push("sc_result", succ ? 32'd0 : 32'd1);
        m_rv = 0;
      end
      OP_ST: begin
        push("stall_cycles", 0);
        push("wen_cycles", 1);
        push("ren_cycles", 0);
        if (same_blk(ad, m_ra)) m_rv = 0;
      end
      default: begin
        push("stall_cycles", 0);
        push("wen_cycles", 0);
        push("ren_cycles", 1);
      end
    endcase
    push("resv_valid", {31'd0, m_rv});
    if (m_rv) push("resv_addr", m_ra);

    @(posedge CLK); #1;
    mem_valid = 1; addr = ad;
    atomic    = (op == OP_LR) || (op == OP_SC);
    mem_read  = (op == OP_LR) || (op == OP_LD);
    mem_write = (op == OP_SC) || (op == OP_ST);
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      if (cyc > 0) begin @(posedge CLK); #1; end
      dhit       = (op >= OP_ST) ? 1'b1 : (cyc == lat);
      snoop_inv  = snp_dhit && (cyc == lat);
      snoop_addr = ad;
      #1;
      stall_n += int'(atomic_stall);
      wen_n   += int'(dmem_wen);
      ren_n   += int'(dmem_ren);
      if (op >= OP_ST || (cyc > 0 && !atomic_stall)) begin
        done    = 1;
        scr_obs = sc_result;
      end
    end
    if (!done) check("op_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    idle_inputs();
    #1;
    $display("op=%0d addr=0x%0h lat=%0d snp=%0d stall=%0d wen=%0d ren=%0d scr=%0d",
             op, ad, lat, snp_dhit, stall_n, wen_n, ren_n, scr_obs);
    drain(stall_n, wen_n, ren_n, scr_obs);
  endtask

  // Snoop invalidation while MEM is idle.
  task automatic do_snoop(input logic [31:0] sa);
    if (m_rv && same_blk(sa, m_ra)) m_rv = 0;
    push("resv_valid", {31'd0, m_rv});
    @(posedge CLK); #1;
    snoop_inv = 1; snoop_addr = sa;
    @(posedge CLK); #1;
    snoop_inv = 0;
    #1;
    $display("snoop addr=0x%0h", sa);
    drain(0, 0, 0, 0);
  endtask

  logic [31:0] addr_tbl [4];

  initial begin
    addr_tbl[0] = 32'h100; addr_tbl[1] = 32'h104; addr_tbl[2] = 32'h108; addr_tbl[3] = 32'h200;

    // Reset with an LR presented: nothing may be requested.
    mem_valid = 1; atomic = 1; mem_read = 1; addr = 32'h100;
    #12;
    check("rst_ren", {31'd0, dmem_ren}, 0);
    check("rst_wen", {31'd0, dmem_wen}, 0);
    check("rst_stall", {31'd0, atomic_stall}, 0);
    check("rst_rv", {31'd0, resv_valid}, 0);
    check("rst_ra", resv_addr, 0);
    check("rst_scr", sc_result, 0);
    idle_inputs();
    #3 nRST = 1;

    // LR then SC to the same block succeeds.
    run_op(OP_LR, 32'h100, 2, 0);
    run_op(OP_SC, 32'h104, 2, 0);
    // Snoop kills the reservation; SC fails without touching the dcache.
    run_op(OP_LR, 32'h100, 2, 0);
    do_snoop(32'h100);
    run_op(OP_SC, 32'h100, 2, 0);
    // SC without reservation, and SC to a different block.
    run_op(OP_SC, 32'h200, 1, 0);
    run_op(OP_LR, 32'h200, 1, 0);
    run_op(OP_SC, 32'h300, 1, 0);
    // Snoop in the LR dhit cycle wins over the reservation set.
    run_op(OP_LR, 32'h100, 2, 1);
    // Plain store to the reserved block clears it; plain load passes through.
    run_op(OP_LR, 32'h100, 1, 0);
    run_op(OP_LD, 32'h100, 1, 0);
    run_op(OP_ST, 32'h100, 1, 0);
    // A new LR overwrites the previous reservation.
    run_op(OP_LR, 32'h100, 1, 0);
    run_op(OP_LR, 32'h20C, 3, 0);

    // Reset asserted mid SC_WAIT.
    run_op(OP_LR, 32'h100, 1, 0);
    @(posedge CLK); #1;
    mem_valid = 1; atomic = 1; mem_write = 1; addr = 32'h100;
    @(posedge CLK); #1;
    check("scwait_wen", {31'd0, dmem_wen}, 1);
    nRST = 0;
    #1;
    check("midrst_wen", {31'd0, dmem_wen}, 0);
    check("midrst_stall", {31'd0, atomic_stall}, 0);
    check("midrst_rv", {31'd0, resv_valid}, 0);
    idle_inputs();
    m_rv = 0; m_ra = 0;
    #6 nRST = 1;

    // Halt drops a live reservation.
    run_op(OP_LR, 32'h180, 1, 0);
    @(posedge CLK); #1;
    halt = 1;
    @(posedge CLK); #1;
    halt = 0;
    #1;
    check("halt_rv", {31'd0, resv_valid}, 0);
    m_rv = 0;

    // Random mix against the model.
    for (int i = 0; i < 40; i++) begin
      int          k;
      logic [31:0] a;
      k = int'($urandom_range(0, 4));
      a = addr_tbl[$urandom_range(0, 3)];
      if (k == 4) do_snoop(a);
      else run_op(k, a, int'($urandom_range(1, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/llsc_reservation_unit.md
Name: llsc_reservation_unit

Overview:
- Memory-stage block downstream of the control unit. Consumes the decoded atomic, Mem_Read and Mem_Write flags for the instruction in MEM.
- Implements RISC-V LR.W/SC.W for each core. Holds one reservation (valid bit plus block address) and clears it on coherence snoop invalidations.
- Gates the store request for SC to the dcache and produces the SC result word. Stalls the pipeline until each atomic access completes.

Parameters:
ADDR_W, 32, address width
GRAN_BITS, 3, low address bits ignored in reservation match (3 = 2-word cache block)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
mem_valid  in  1  valid instruction in MEM stage
atomic  in  1  control unit atomic flag
mem_read  in  1  control unit Mem_Read
mem_write  in  1  control unit Mem_Write
halt  in  1  core halt
addr  in  ADDR_W  effective address of MEM instruction
dhit  in  1  dcache access complete this cycle
snoop_inv  in  1  coherence invalidation from another core
snoop_addr  in  ADDR_W  address of snoop invalidation
dmem_ren  out  1  read request to dcache
dmem_wen  out  1  write request to dcache
sc_result  out  32  SC writeback value: 0 = success, 1 = fail
atomic_stall  out  1  hold pipeline upstream of MEM
resv_valid  out  1  reservation valid (debug/verification)
resv_addr  out  ADDR_W  reserved address, low GRAN_BITS forced 0

Behaviour:
- Reset (nRST low, async): state=IDLE, resv_valid=0, resv_addr=0, sc_result=0. All request/stall outputs are 0.
- Block match: match(a,b) = a[ADDR_W-1:GRAN_BITS]==b[ADDR_W-1:GRAN_BITS].
- Decode (sampled in IDLE when mem_valid=1):
  - LR = atomic & mem_read
  - SC = atomic & mem_write
  - plain store = !atomic & mem_write
  - plain load = !atomic & mem_read; plain loads pass through, dmem_ren = mem_read combinationally.
- Plain store:
  - dmem_wen = 1 combinationally.
  - When dhit and match(addr, resv_addr): resv_valid <= 0.
- States: IDLE, LR_WAIT, SC_WAIT, SC_FAIL.
- IDLE:
  - LR: go to LR_WAIT. dmem_ren=1, atomic_stall=1 combinationally in the entry cycle.
  - SC with resv_valid & match(addr, resv_addr), and no same-cycle matching snoop_inv: go to SC_WAIT. dmem_wen=1, atomic_stall=1.
  - SC otherwise: go to SC_FAIL. dmem_wen=0, atomic_stall=1, resv_valid <= 0.
- LR_WAIT:
  - dmem_ren=1, atomic_stall=1.
  - On dhit: resv_valid <= 1, resv_addr <= addr with low bits zeroed, go to IDLE. atomic_stall=0 in the dhit cycle.
  - If dhit and a matching snoop_inv arrive in the same cycle: reservation is not set (resv_valid <= 0).
- SC_WAIT:
  - dmem_wen=1, atomic_stall=1.
  - On dhit: sc_result <= 0, resv_valid <= 0, go to IDLE. atomic_stall=0 in the dhit cycle.
  - snoop_inv during SC_WAIT does not change the result; dcache arbitration orders the write.
- SC_FAIL:
  - One cycle only. sc_result=1, atomic_stall=0, go to IDLE.
  - No dcache request is issued.
- sc_result:
  - In SC_FAIL: 1 combinationally.
  - In SC_WAIT dhit cycle: 0 combinationally.
  - Otherwise: holds the registered value.
- Snoop:
  - In any state, snoop_inv & resv_valid & match(snoop_addr, resv_addr) gives resv_valid <= 0 next edge.
  - Snoop clear has priority over LR set when both occur in the same cycle.
- Halt:
  - halt=1 gives resv_valid <= 0.
  - State returns to IDLE next edge with no request outstanding.
- A new LR while a reservation exists overwrites resv_addr (single reservation per core).
- Reset mid-operation (nRST low in LR_WAIT or SC_WAIT): immediate IDLE, requests drop the same instant, reservation is lost.
- Latency:
  - LR and successful SC: 1 + dcache latency cycles.
  - Failed SC: 2 cycles (IDLE decode + SC_FAIL), zero memory traffic.

Test Plan:
- Reset with nRST low: resv_valid=0, dmem_ren=0, dmem_wen=0, atomic_stall=0. Release nRST -> state IDLE.
- LR 0x100, dhit after 2 cycles -> resv_valid=1, resv_addr=0x100. Then SC 0x104 (same block) -> dmem_wen=1 until dhit, sc_result=0, resv_valid=0.
- LR 0x100; then snoop_inv with snoop_addr=0x100; then SC 0x100 -> SC_FAIL, dmem_wen never asserted, sc_result=1, atomic_stall high exactly 1 cycle.
- SC 0x200 with no reservation -> sc_result=1, no dcache write. LR 0x200 then SC 0x300 -> fail, reservation cleared.
- LR 0x100 with a matching snoop_inv in the dhit cycle -> resv_valid stays 0. Plain store to 0x100 after a valid LR -> resv_valid=0.
- Assert nRST low during SC_WAIT -> dmem_wen=0 and atomic_stall=0 immediately, resv_valid=0. Also assert halt with resv_valid=1 -> resv_valid=0 next edge.
